// File: rtl/spec_adder_ctrl.sv
// Block-speculative approximate adder sequencer.
// Speculates each block carry-in, optionally repairs carries until exact.
module spec_adder_ctrl #(
  parameter int WIDTH = 16,
  parameter int BLK = 4,
  parameter int NBLK = 4,
  localparam int PW = $clog2(NBLK)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             exact_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             err_det,
  output logic [PW-1:0]    fix_cycles,
  output logic [15:0]      err_count
);

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    DONE
  } state_t;

  state_t state;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             exact_q;
  logic [NBLK-1:0]  c;
  logic [PW-1:0]    pass;
  logic             err_first;

  logic [NBLK-1:0]  co;
  logic [WIDTH-1:0] s_comb;
  logic [NBLK-1:0]  mism;
  logic [NBLK-1:0]  c_fix;
  logic [NBLK-1:0]  c_spec;
  logic             err_now;
  logic             settled;

  // Per-block sums from latched operands and current carry guesses
  always_comb begin
    co = '0;
    s_comb = '0;
    for (int i = 0; i < NBLK; i++) begin
      {co[i], s_comb[i*BLK +: BLK]} =
        {1'b0, a_q[i*BLK +: BLK]} +
        {1'b0, b_q[i*BLK +: BLK]} +
        {{BLK{1'b0}}, c[i]};
    end
  end

  // Carry mismatches and the repaired carry vector for the next pass
  always_comb begin
    mism = '0;
    c_fix = c;
    for (int i = 1; i < NBLK; i++) begin
      mism[i] = c[i] ^ co[i-1];
      c_fix[i] = co[i-1];
    end
  end

  // Initial guess: block carry-in = generate bit of previous block's MSB
  always_comb begin
    c_spec = '0;
    c_spec[0] = cin;
    for (int i = 1; i < NBLK; i++) begin
      c_spec[i] = a[BLK*i-1] & b[BLK*i-1];
    end
  end

  // First-pass error flag, captured live on pass 0
  always_comb begin
    err_now = (pass == '0) ? (|mism) : err_first;
    settled = !exact_q || (mism == '0);
  end

  // Sequencer with registered handshake and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      sum        <= '0;
      cout       <= 1'b0;
      err_det    <= 1'b0;
      fix_cycles <= '0;
      err_count  <= '0;
      a_q        <= '0;
      b_q        <= '0;
      exact_q    <= 1'b0;
      c          <= '0;
      pass       <= '0;
      err_first  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q       <= a;
            b_q       <= b;
            exact_q   <= exact_en;
            c         <= c_spec;
            pass      <= '0;
            err_first <= 1'b0;
            in_ready  <= 1'b0;
            state     <= EVAL;
          end
        end
        EVAL: begin
          if (pass == '0) err_first <= |mism;
          if (settled) begin
            sum        <= s_comb;
            cout       <= co[NBLK-1];
            err_det    <= err_now;
            fix_cycles <= pass;
            out_valid  <= 1'b1;
            state      <= DONE;
            if (err_now && (err_count != 16'hFFFF))
              err_count <= err_count + 16'd1;
          end else begin
            c    <= c_fix;
            pass <= pass + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
